// File: rtl/wisc_pkg.sv
// ---------------------------------------------------------------------------
// wisc_pkg
// Shared constants and types for the WISC pipeline stages.
//   WISC_DATA_WIDTH : width of PC and instruction words
//   WISC_NOP_INSTR  : bubble instruction placed into stage registers
//   HALT_OPCODE     : opcode field value (instr[15:11]) that stops fetch
//   fetch_state_t   : fetch FSM state encoding
// ---------------------------------------------------------------------------
package wisc_pkg;

    localparam int          WISC_DATA_WIDTH = 16;
    localparam logic [15:0] WISC_NOP_INSTR  = 16'h0800;
    localparam logic [4:0]  HALT_OPCODE     = 5'b00000;

    typedef enum logic [1:0] {
        FS_FETCH  = 2'd0,
        FS_WAIT   = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_latch.sv
// ---------------------------------------------------------------------------
// if_id_latch
// Generic pipeline stage register: instruction, sequential PC and valid bit.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_load              : capture i_instr / i_seq_pc, mark valid
//   i_flush             : insert NOP_INSTR bubble (wins over i_load)
//   i_instr, i_seq_pc   : incoming instruction and its PC+2
//   o_instr, o_seq_pc   : registered instruction and PC+2
//   o_valid             : 1 = real instruction, 0 = bubble
// Neither load nor flush: contents held.
// ---------------------------------------------------------------------------
module if_id_latch
    import wisc_pkg::*;
#(
    parameter int                    DATA_WIDTH = WISC_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = WISC_NOP_INSTR
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_instr,
    input  logic [DATA_WIDTH-1:0] i_seq_pc,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [DATA_WIDTH-1:0] o_seq_pc,
    output logic                  o_valid
);

    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] r_seq_pc;
    logic                  r_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instr  <= NOP_INSTR;
            r_seq_pc <= '0;
            r_valid  <= 1'b0;
        end else if (i_flush) begin
            r_instr  <= NOP_INSTR;
            r_valid  <= 1'b0;
        end else if (i_load) begin
            r_instr  <= i_instr;
            r_seq_pc <= i_seq_pc;
            r_valid  <= 1'b1;
        end
    end

    assign o_instr  = r_instr;
    assign o_seq_pc = r_seq_pc;
    assign o_valid  = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: owns the PC, reads instruction memory (zero-wait or
// multi-cycle) and drives the IF/ID register feeding decode.
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_stall                : hazard stall, hold IF/ID and PC
//   i_redirect_en/_pc      : taken branch/jump, flush and refetch at target
//   o_imem_rd_en/_addr     : memory read request / address
//   i_imem_data/_done      : memory read data / completion
//   o_instruc_pipe         : IF/ID instruction
//   o_seq_pc_pipe          : IF/ID PC+2
//   o_valid_pipe           : IF/ID holds a real instruction
//   o_halted               : fetch stopped on HALT
//
// state     | meaning
// FS_FETCH  | issue read at PC (suppressed while hold buffer is full)
// FS_WAIT   | read outstanding at r_wait_addr, waiting for done
// FS_HALTED | HALT reached decode, no reads until a redirect
// ---------------------------------------------------------------------------
module fetch_stage
    import wisc_pkg::*;
#(
    parameter int                    DATA_WIDTH = WISC_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = WISC_NOP_INSTR
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic                  i_redirect_en,
    input  logic [DATA_WIDTH-1:0] i_redirect_pc,
    output logic                  o_imem_rd_en,
    output logic [DATA_WIDTH-1:0] o_imem_addr,
    input  logic [DATA_WIDTH-1:0] i_imem_data,
    input  logic                  i_imem_done,
    output logic [DATA_WIDTH-1:0] o_instruc_pipe,
    output logic [DATA_WIDTH-1:0] o_seq_pc_pipe,
    output logic                  o_valid_pipe,
    output logic                  o_halted
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(2);

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_wait_addr;
    logic [DATA_WIDTH-1:0] r_buf_instr;
    logic [DATA_WIDTH-1:0] r_buf_seq_pc;
    logic                  r_buf_valid;
    logic                  r_discard;

    logic                  w_mem_done;
    logic                  w_accept;
    logic                  w_accept_halt;
    logic                  w_drain;
    logic                  w_load;
    logic                  w_flush;
    logic                  w_load_halt;
    logic [DATA_WIDTH-1:0] w_pc_inc;
    logic [DATA_WIDTH-1:0] w_load_instr;
    logic [DATA_WIDTH-1:0] w_load_seq_pc;

    assign w_pc_inc      = r_pc + PC_STEP;
    assign w_mem_done    = o_imem_rd_en & i_imem_done;
    // Data returned in a redirect cycle, or for a read started before an
    // earlier redirect, belongs to the wrong path and is dropped.
    assign w_accept      = w_mem_done & ~r_discard & ~i_redirect_en;
    assign w_accept_halt = w_accept & (i_imem_data[DATA_WIDTH-1 -: 5] == HALT_OPCODE);
    assign w_drain       = r_buf_valid & ~i_stall & ~i_redirect_en;
    assign w_load        = w_drain | (w_accept & ~i_stall);
    assign w_flush       = i_redirect_en | (~i_stall & ~w_load);
    assign w_load_instr  = w_drain ? r_buf_instr  : i_imem_data;
    assign w_load_seq_pc = w_drain ? r_buf_seq_pc : w_pc_inc;
    assign w_load_halt   = w_load & (w_load_instr[DATA_WIDTH-1 -: 5] == HALT_OPCODE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= FS_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_redirect_en) begin
            // An outstanding read must still complete at its old address.
            w_state_nxt = (r_state == FS_WAIT && !i_imem_done) ? FS_WAIT : FS_FETCH;
        end else if (w_load_halt) begin
            w_state_nxt = FS_HALTED;
        end else begin
            case (r_state)
                FS_FETCH:  if (o_imem_rd_en && !i_imem_done) w_state_nxt = FS_WAIT;
                FS_WAIT:   if (i_imem_done) w_state_nxt = FS_FETCH;
                FS_HALTED: w_state_nxt = FS_HALTED;
                default:   w_state_nxt = FS_FETCH;
            endcase
        end
    end

    always_comb begin
        o_imem_rd_en = 1'b0;
        o_imem_addr  = r_pc;
        o_halted     = 1'b0;
        case (r_state)
            FS_FETCH: o_imem_rd_en = ~r_buf_valid;
            FS_WAIT: begin
                o_imem_rd_en = 1'b1;
                o_imem_addr  = r_wait_addr;
            end
            FS_HALTED: o_halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc         <= RESET_PC;
            r_wait_addr  <= RESET_PC;
            r_buf_instr  <= NOP_INSTR;
            r_buf_seq_pc <= '0;
            r_buf_valid  <= 1'b0;
            r_discard    <= 1'b0;
        end else begin
            // Address of a read is frozen once it leaves FETCH, so the PC
            // may move to a redirect target while the old read drains.
            if (r_state == FS_FETCH) begin
                r_wait_addr <= r_pc;
            end
            if (i_redirect_en) begin
                r_pc        <= i_redirect_pc;
                r_buf_valid <= 1'b0;
                r_discard   <= (r_state == FS_WAIT) & ~i_imem_done;
            end else begin
                if (w_accept && !w_accept_halt) begin
                    r_pc <= w_pc_inc;
                end
                if (w_accept && i_stall) begin
                    r_buf_valid  <= 1'b1;
                    r_buf_instr  <= i_imem_data;
                    r_buf_seq_pc <= w_pc_inc;
                end else if (w_drain) begin
                    r_buf_valid <= 1'b0;
                end
                if (w_mem_done) begin
                    r_discard <= 1'b0;
                end
            end
        end
    end

    if_id_latch #(
        .DATA_WIDTH (DATA_WIDTH),
        .NOP_INSTR  (NOP_INSTR)
    ) u_if_id (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_load),
        .i_flush  (w_flush),
        .i_instr  (w_load_instr),
        .i_seq_pc (w_load_seq_pc),
        .o_instr  (o_instruc_pipe),
        .o_seq_pc (o_seq_pc_pipe),
        .o_valid  (o_valid_pipe)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Bench for fetch_stage. Acts as instruction memory with configurable or
// random latency. Directed scenarios check exact cycle behaviour; a random
// phase checks the delivered instruction stream against program order
// (sequential PCs, restarting at each redirect target).
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk;
    logic        i_rst;
    logic        i_stall;
    logic        i_redirect_en;
    logic [15:0] i_redirect_pc;
    logic        o_imem_rd_en;
    logic [15:0] o_imem_addr;
    logic [15:0] i_imem_data;
    logic        i_imem_done;
    logic [15:0] o_instruc_pipe;
    logic [15:0] o_seq_pc_pipe;
    logic        o_valid_pipe;
    logic        o_halted;

    fetch_stage dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_stall        (i_stall),
        .i_redirect_en  (i_redirect_en),
        .i_redirect_pc  (i_redirect_pc),
        .o_imem_rd_en   (o_imem_rd_en),
        .o_imem_addr    (o_imem_addr),
        .i_imem_data    (i_imem_data),
        .i_imem_done    (i_imem_done),
        .o_instruc_pipe (o_instruc_pipe),
        .o_seq_pc_pipe  (o_seq_pc_pipe),
        .o_valid_pipe   (o_valid_pipe),
        .o_halted       (o_halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int n_deliv = 0;

    // stimulus knobs
    logic        rst_v, stall_v, redir_v;
    logic [15:0] redir_pc_v;
    int          lat_cfg;
    bit          lat_rand;
    bit          use_hash;
    bit          sb_on;

    // memory responder state
    bit          mem_busy;
    int          mem_left;
    logic [15:0] dmem [logic [15:0]];

    // snapshot of the cycle just before the edge
    logic        p_rst, p_stall, p_redir, p_rd_en, p_done, p_valid;
    logic [15:0] p_redir_pc, p_addr, p_instr, p_seq;

    logic [15:0] exp_pc;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] h;
        if (!use_hash && dmem.exists(a)) return dmem[a];
        h = a * 16'h9E37;
        return (h ^ 16'h5A5A) | 16'h0800;   // opcode never HALT
    endfunction

    // Program-order reference: every real instruction reaching decode must be
    // the word at the next expected PC; stalls freeze decode's view; redirects
    // bubble and restart the expected stream at the target.
    task automatic scoreboard();
        if (p_rst) begin
            exp_pc = 16'h0000;
            chk("rst_bubble", {o_valid_pipe, o_instruc_pipe}, {1'b0, NOP});
        end else if (p_redir) begin
            chk("redir_bubble", {o_valid_pipe, o_instruc_pipe}, {1'b0, NOP});
            exp_pc = p_redir_pc;
            if (!p_rd_en || p_done)
                chk("redir_addr", {o_imem_rd_en, o_imem_addr}, {1'b1, p_redir_pc});
        end else if (p_stall) begin
            chk("stall_hold", {o_valid_pipe, o_instruc_pipe, o_seq_pc_pipe},
                {p_valid, p_instr, p_seq});
        end else if (o_valid_pipe) begin
            chk("order", {o_instruc_pipe, o_seq_pc_pipe}, {mem_word(exp_pc), exp_pc + 16'd2});
            exp_pc = exp_pc + 16'd2;
            n_deliv++;
        end else begin
            chk("bubble", o_instruc_pipe, NOP);
        end
        if (!p_rst && p_rd_en && !p_done && !p_redir)
            chk("addr_hold", {o_imem_rd_en, o_imem_addr}, {1'b1, p_addr});
    endtask

    task automatic tick();
        @(negedge clk);
        i_rst         = rst_v;
        i_stall       = stall_v;
        i_redirect_en = redir_v;
        i_redirect_pc = redir_pc_v;
        if (rst_v || !o_imem_rd_en) begin
            mem_busy    = 1'b0;
            i_imem_done = 1'b0;
            i_imem_data = 16'($urandom);
        end else begin
            if (!mem_busy) begin
                mem_left = lat_rand ? int'($urandom_range(0, 2)) : lat_cfg;
                mem_busy = 1'b1;
            end
            if (mem_left == 0) begin
                i_imem_done = 1'b1;
                i_imem_data = mem_word(o_imem_addr);
                mem_busy    = 1'b0;
            end else begin
                i_imem_done = 1'b0;
                i_imem_data = 16'($urandom);
                mem_left--;
            end
        end
        p_rst = rst_v; p_stall = stall_v; p_redir = redir_v; p_redir_pc = redir_pc_v;
        p_rd_en = o_imem_rd_en; p_addr = o_imem_addr; p_done = i_imem_done;
        p_instr = o_instruc_pipe; p_seq = o_seq_pc_pipe; p_valid = o_valid_pipe;
        @(posedge clk);
        #1;
        if (sb_on) scoreboard();
    endtask

    task automatic do_reset();
        stall_v = 1'b0; redir_v = 1'b0; redir_pc_v = 16'h0000;
        dmem.delete();
        rst_v = 1'b1;
        tick();
        tick();
        rst_v = 1'b0;
    endtask

    task automatic pipe_is(input string tag, input logic [15:0] ins, input logic [15:0] seq,
                           input logic vld);
        chk(tag, {o_instruc_pipe, o_seq_pc_pipe, o_valid_pipe}, {ins, seq, vld});
    endtask

    initial begin
        i_rst = 1'b1; i_stall = 1'b0; i_redirect_en = 1'b0; i_redirect_pc = 16'h0;
        i_imem_data = 16'h0; i_imem_done = 1'b0;
        lat_cfg = 0; lat_rand = 1'b0; use_hash = 1'b0; sb_on = 1'b0;
        mem_busy = 1'b0; mem_left = 0; exp_pc = 16'h0;
        stall_v = 1'b0; redir_v = 1'b0; redir_pc_v = 16'h0; rst_v = 1'b1;

        // reset state and zero-wait streaming
        do_reset();
        pipe_is("reset_pipe", NOP, 16'h0000, 1'b0);
        chk("reset_halted", o_halted, 1'b0);
        dmem[16'h0] = 16'h4000; dmem[16'h2] = 16'h4100; dmem[16'h4] = 16'h4200;
        tick();
        chk("rd_after_rst", {p_rd_en, p_addr}, {1'b1, 16'h0000});
        pipe_is("zw_0", 16'h4000, 16'h0002, 1'b1);
        tick();
        pipe_is("zw_1", 16'h4100, 16'h0004, 1'b1);
        tick();
        pipe_is("zw_2", 16'h4200, 16'h0006, 1'b1);

        // 3-cycle memory: address held, two bubbles per instruction
        do_reset();
        dmem[16'h0] = 16'h4000; dmem[16'h2] = 16'h4100;
        lat_cfg = 2;
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < 2; b++) begin
                tick();
                pipe_is("slow_bubble", NOP, (k == 0) ? 16'h0000 : 16'h0002, 1'b0);
                chk("slow_addr", {o_imem_rd_en, o_imem_addr}, {1'b1, 16'(2 * k)});
            end
            tick();
            pipe_is("slow_instr", (k == 0) ? 16'h4000 : 16'h4100, 16'(2 * k + 2), 1'b1);
        end
        lat_cfg = 0;

        // stall while 16'h4100 arrives
        do_reset();
        dmem[16'h0] = 16'h4000; dmem[16'h2] = 16'h4100; dmem[16'h4] = 16'h4200;
        tick();
        pipe_is("st_first", 16'h4000, 16'h0002, 1'b1);
        stall_v = 1'b1;
        tick();
        pipe_is("st_hold1", 16'h4000, 16'h0002, 1'b1);
        tick();
        pipe_is("st_hold2", 16'h4000, 16'h0002, 1'b1);
        chk("st_no_read", o_imem_rd_en, 1'b0);
        stall_v = 1'b0;
        tick();
        pipe_is("st_drain", 16'h4100, 16'h0004, 1'b1);
        tick();
        pipe_is("st_next", 16'h4200, 16'h0006, 1'b1);

        // redirect during WAIT: old read completes at old address and is dropped
        do_reset();
        dmem[16'h0040] = 16'h4500;
        lat_cfg = 3;
        tick();
        redir_v = 1'b1; redir_pc_v = 16'h0040;
        tick();
        redir_v = 1'b0;
        pipe_is("rw_bubble", NOP, 16'h0000, 1'b0);
        chk("rw_old_addr", {o_imem_rd_en, o_imem_addr}, {1'b1, 16'h0000});
        tick();
        tick();
        pipe_is("rw_dropped", NOP, 16'h0000, 1'b0);
        chk("rw_new_addr", {o_imem_rd_en, o_imem_addr}, {1'b1, 16'h0040});
        lat_cfg = 0;
        tick();
        pipe_is("rw_target", 16'h4500, 16'h0042, 1'b1);

        // HALT at 0x0008, then redirect to 0x0020
        do_reset();
        dmem[16'h0] = 16'h4000; dmem[16'h2] = 16'h4100; dmem[16'h4] = 16'h4200;
        dmem[16'h6] = 16'h4300; dmem[16'h8] = 16'h0000; dmem[16'h20] = 16'h4600;
        for (int k = 0; k < 5; k++) tick();
        pipe_is("halt_instr", 16'h0000, 16'h000A, 1'b1);
        chk("halt_state", {o_halted, o_imem_rd_en, o_imem_addr}, {1'b1, 1'b0, 16'h0008});
        tick();
        pipe_is("halt_bubble", NOP, 16'h000A, 1'b0);
        chk("halt_stays", {o_halted, o_imem_rd_en, o_imem_addr}, {1'b1, 1'b0, 16'h0008});
        redir_v = 1'b1; redir_pc_v = 16'h0020;
        tick();
        redir_v = 1'b0;
        chk("unhalt", {o_halted, o_imem_rd_en, o_imem_addr}, {1'b0, 1'b1, 16'h0020});
        tick();
        pipe_is("resume", 16'h4600, 16'h0022, 1'b1);

        // PC wrap at 0xFFFE
        do_reset();
        dmem[16'h0] = 16'h4000; dmem[16'hFFFE] = 16'h4700; dmem[16'h2] = 16'h4100;
        redir_v = 1'b1; redir_pc_v = 16'hFFFE;
        tick();
        redir_v = 1'b0;
        chk("wrap_addr", o_imem_addr, 16'hFFFE);
        tick();
        pipe_is("wrap_instr", 16'h4700, 16'h0000, 1'b1);
        chk("wrap_next_addr", o_imem_addr, 16'h0000);
        tick();
        pipe_is("wrap_after", 16'h4000, 16'h0002, 1'b1);

        // random phase against program-order model
        do_reset();
        use_hash = 1'b1;
        lat_rand = 1'b1;
        exp_pc   = 16'h0000;
        sb_on    = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst_v      = (c == 1500);
            stall_v    = ($urandom_range(0, 3) == 0);
            redir_v    = ($urandom_range(0, 24) == 0);
            redir_pc_v = ($urandom_range(0, 3) == 0) ? 16'hFFFC : (16'($urandom) & 16'hFFFE);
            tick();
        end
        sb_on = 1'b0;
        chk("progress", {47'd0, (n_deliv >= 200)}, 48'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage WISC pipeline, directly upstream of decode. Owns the PC, issues reads to instruction memory (single- or multi-cycle), and drives the IF/ID pipeline register that supplies decode's `instruc` and `seq_PC`. Honours hazard stalls, branch/jump redirects (flush), and HALT detection.

## Interface
- `DATA_WIDTH`, 16, width of PC and instruction words.
- `RESET_PC`, 16'h0000, PC value after reset.
- `NOP_INSTR`, 16'h0800, bubble inserted into IF/ID on flush/halt.
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  reset. Synchronous and active-high.
- `stall`  in  1  hazard unit: hold IF/ID and PC.
- `redirect_en`  in  1  resolved taken branch/jump: flush and refetch.
- `redirect_PC`  in  16  target address, valid when `redirect_en`.
- `imem_rd_en`  out  1  read request.
- `imem_addr`  out  16  read address; stable while a read is outstanding.
- `imem_data`  in  16  instruction, valid when `imem_done`.
- `imem_done`  in  1  read complete; may be high in the same cycle as `imem_rd_en` (zero-wait memory).
- `instruc_pipe`  out  16  IF/ID instruction to decode.
- `seq_PC_pipe`  out  16  IF/ID PC+2 to decode.
- `valid_pipe`  out  1  IF/ID holds a real instruction (0 = bubble).
- `halted`  out  1  fetch stopped on HALT.

## Operation
- States: FETCH, WAIT, HALTED. Priority: `rst` > `redirect_en` > `stall` > normal.
- FETCH: `imem_rd_en`=1, `imem_addr`=PC. If `imem_done`, instruction is accepted this cycle; else go WAIT.
- WAIT: `imem_rd_en`=1, address held. On `imem_done`, accept, return to FETCH.
- Accept: if `stall`=0, load IF/ID (`instruc_pipe`=data, `seq_PC_pipe`=PC+2, `valid_pipe`=1) and PC<=PC+2 (16-bit wrap, 16'hFFFE+2=16'h0000). If `stall`=1, data goes into a one-entry hold buffer, PC advances; no new read issued while the buffer is full; buffer drains into IF/ID on the first cycle `stall`=0.
- `stall`=1 with no accept: IF/ID, PC unchanged.
- HALT: opcode `instruc[15:11]`=5'b00000 loaded into IF/ID -> state HALTED, PC not advanced. HALTED: `imem_rd_en`=0, `halted`=1; each non-stalled cycle loads NOP_INSTR with `valid_pipe`=0.
- Redirect (any state, overrides `stall`): IF/ID <= NOP_INSTR, `valid_pipe`=0, hold buffer cleared, PC <= `redirect_PC`, state -> FETCH, `halted`=0. If a read is outstanding (WAIT without `imem_done` this cycle), set a discard flag: stay in WAIT at the old address until `imem_done`, drop that data, then FETCH at the new PC.
- Redirect and `imem_done` in the same cycle: data dropped.

## Timing
- Reset values: PC=RESET_PC, `instruc_pipe`=NOP_INSTR, `seq_PC_pipe`=0, `valid_pipe`=0, `halted`=0, buffer empty, discard=0, state FETCH. `imem_rd_en` is 1 in the first cycle after `rst` falls.
- Zero-wait memory: 1 instruction/cycle; data at `imem_addr`=A appears in `instruc_pipe` at the next edge with `seq_PC_pipe`=A+2.
- N-cycle memory: N cycles per instruction; IF/ID keeps its previous contents (not a bubble) during WAIT when not stalled? No: it loads NOP_INSTR, `valid_pipe`=0, each non-stalled cycle with no accept.
- Redirect latency: `imem_addr`=target in the cycle after `redirect_en` (zero outstanding read).
- `rst` mid-WAIT abandons the read. Memory must tolerate a dropped request.

## Structure
- Shared package `wisc_pkg`: NOP_INSTR, HALT opcode 5'b00000, fetch state encoding, DATA_WIDTH.
- Sub-module `if_id_latch`: IF/ID register with load/flush/hold controls plus the valid bit. Reused by the pipeline team for the later stage registers.
- Top holds PC, hold buffer, discard flag, FSM.

## Test plan
- Reset, zero-wait memory returning 16'h4000, 16'h4100, 16'h4200 -> `instruc_pipe` sequence matches with `seq_PC_pipe` 2, 4, 6, and `valid_pipe`=1 each cycle.
- 3-cycle memory -> `imem_addr` held 3 cycles, two bubbles (`valid_pipe`=0, NOP 16'h0800) between instructions.
- `stall` high 2 cycles as 16'h4100 arrives -> IF/ID holds 16'h4000, then 16'h4100 loads on release, no instruction lost or duplicated.
- `redirect_en` with `redirect_PC`=16'h0040 during WAIT -> old data discarded, next `imem_addr`=16'h0040, IF/ID bubble.
- Fetch 16'h0000 at PC 16'h0008 -> `halted`=1, `imem_rd_en`=0, PC stays 16'h0008. Then redirect to 16'h0020 -> fetch resumes at 16'h0020.
- PC=16'hFFFE fetch -> `seq_PC_pipe`=16'h0000, next `imem_addr`=16'h0000.
